multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. It fetches an instruction over a valid-handshake memory port and latches it into the instruction register (IR). It then steps the datapath through decode, execute, memory and writeback states. It drives the one-hot instruction-format vector consumed by the immediate generator and decoder, plus the PC, register-file, data-memory and retire strobes.

## Interface
Parameters:
- RETIRE_W, default 32: width of retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_imem_req  out  1  instruction fetch request.
- i_imem_valid  in  1  fetch data valid.
- i_imem_rdata  in  32  fetched instruction word.
- o_dmem_ren  out  1  data read request (loads).
- o_dmem_wen  out  1  data write request (stores).
- i_dmem_valid  in  1  data access complete.
- o_inst  out  32  IR contents.
- o_format  out  6  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J; 0 = illegal/none.
- o_rf_we  out  1  register-file write enable.
- o_pc_we  out  1  PC update strobe.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_retire_count  out  RETIRE_W  retired-instruction count.
- o_trap  out  1  illegal opcode seen; sticky.

## Operation
- Opcode (IR[6:0]) decode:
  - 0110011 is R-type.
  - 0010011 (OP-IMM), 0000011 (LOAD) and 1100111 (JALR) are I-type.
  - 0100011 is S-type.
  - 1100011 is B-type.
  - 0110111 and 0010111 are U-type.
  - 1101111 is J-type.
  - Anything else is illegal, with o_format = 0.
- o_format is decoded combinationally from the IR at all times.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from the state, except the handshake-qualified strobes noted below.
- FETCH:
  - o_imem_req=1.
  - On i_imem_valid: latch i_imem_rdata into IR and go to DECODE. Otherwise stay.
- DECODE, 1 cycle:
  - Illegal opcode: go to TRAP.
  - Legal opcode: go to EXEC.
- EXEC, 1 cycle:
  - LOAD or STORE: go to MEM.
  - BRANCH: assert o_pc_we and o_retire, then go to FETCH.
  - All other opcodes: go to WB.
- MEM:
  - o_dmem_ren=1 for a load; o_dmem_wen=1 for a store. The request is held until i_dmem_valid.
  - Load: on valid, go to WB.
  - Store: on valid, assert o_pc_we and o_retire in that cycle, then go to FETCH.
- WB, 1 cycle:
  - o_rf_we=1 only when rd (IR[11:7]) != 0.
  - o_pc_we=1 and o_retire=1, then go to FETCH.
- TRAP: o_trap=1, all requests and strobes 0. The state is held until i_rst.
- o_retire_count increments by 1 on every o_retire cycle and wraps modulo 2^RETIRE_W.
- i_imem_valid outside FETCH and i_dmem_valid outside MEM are ignored.

## Timing
- Reset (i_rst high at an edge) sets:
  - state = FETCH
  - IR = 0 (so o_inst=0 and o_format=0)
  - o_trap = 0
  - o_retire_count = 0
- While i_rst is high, o_imem_req, o_dmem_ren, o_dmem_wen, o_rf_we, o_pc_we and o_retire are forced to 0.
- o_imem_req rises in the first cycle after i_rst falls.
- Reset mid-operation abandons any outstanding fetch or data access with no retire. Memory must tolerate a dropped request.
- Cycles per instruction with zero-wait memory (valid in the first request cycle):
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - load: 5
  - store: 4
  - branch: 3
- Each memory wait cycle adds 1.
- A retire count of all-ones plus a retire wraps to 0.
- The IR is stable from the FETCH-accept edge until the next FETCH accept, so o_format is valid in DECODE through the final state.

## Test plan
- Reset then fetch 0x00500093 (addi x1,x0,5) with valid on the first request cycle:
  - o_format=000010.
  - States FETCH, DECODE, EXEC, WB.
  - o_rf_we, o_pc_we and o_retire pulse in cycle 4.
  - o_retire_count=1.
- Load 0x0000A103 with i_dmem_valid delayed 3 cycles:
  - o_dmem_ren high for 4 cycles.
  - WB follows, with o_rf_we=1; retire occurs at cycle 8.
- Store 0x0020A023 followed by branch 0x00208463:
  - Store: o_dmem_wen held until valid, retire in the MEM cycle, o_rf_we never asserted, o_format=000100.
  - Branch: retires in its 3rd cycle, o_format=001000.
- Illegal word 0xFFFFFFFF:
  - TRAP entered after DECODE; o_trap=1 and o_format=0.
  - No further o_imem_req until i_rst, which clears o_trap.
- Reset asserted mid-MEM of a load:
  - o_dmem_ren drops to 0 immediately.
  - No retire occurs; the counter is cleared to 0 and FETCH restarts.
- Counter wrap: RETIRE_W=4, retire 16 ALU instructions, so the count returns to 0. Also covered: addi to x0 (0x00000013) gives o_rf_we=0 while still retiring.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the RV32I core.
// Fetches an instruction over a valid handshake into the IR, then walks the
// datapath through DECODE, EXEC, MEM and WB. Strobes are decoded from the
// state register and forced low while i_rst is high.
//
// Handshake rule for both memory ports: a request (o_imem_req, o_dmem_ren,
// o_dmem_wen) stays asserted every cycle until the matching valid is seen
// high at a rising edge. Valid is only meaningful while the request is
// high; a valid arriving in any other state is ignored. Reset drops any
// outstanding request without a completion.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_req,
    input  logic                i_imem_valid,
    input  logic [31:0]         i_imem_rdata,
    output logic                o_dmem_ren,
    output logic                o_dmem_wen,
    input  logic                i_dmem_valid,
    output logic [31:0]         o_inst,
    output logic [5:0]          o_format,
    output logic                o_rf_we,
    output logic                o_pc_we,
    output logic                o_retire,
    output logic [RETIRE_W-1:0] o_retire_count,
    output logic                o_trap,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t                r_state;
    logic [31:0]           r_ir;
    logic [RETIRE_W-1:0]   r_retire_count;

    logic [6:0]            w_opcode;
    logic [5:0]            w_format;
    logic                  w_legal;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_branch;

    assign w_opcode    = r_ir[6:0];
    assign w_legal     = |w_format;
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);

    // Opcode to one-hot format decode; an unknown opcode yields all zeros.
    always_comb begin
        w_format = 6'b000000;
        case (w_opcode)
            OP_R:                      w_format = 6'b000001;
            OP_IMM, OP_LOAD, OP_JALR:  w_format = 6'b000010;
            OP_STORE:                  w_format = 6'b000100;
            OP_BRANCH:                 w_format = 6'b001000;
            OP_LUI, OP_AUIPC:          w_format = 6'b010000;
            OP_JAL:                    w_format = 6'b100000;
            default:                   w_format = 6'b000000;
        endcase
    end

    // Sequencer state and instruction register; the IR only changes on a fetch accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_ir    <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_imem_valid) begin
                        r_ir    <= i_imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    if (w_is_load || w_is_store) r_state <= S_MEM;
                    else if (w_is_branch)        r_state <= S_FETCH;
                    else                         r_state <= S_WB;
                end
                S_MEM: begin
                    if (i_dmem_valid) r_state <= w_is_load ? S_WB : S_FETCH;
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Moore strobes from the state, with the store completion qualified by
    // i_dmem_valid; everything is held low while reset is asserted.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_ren = 1'b0;
        o_dmem_wen = 1'b0;
        o_rf_we    = 1'b0;
        o_pc_we    = 1'b0;
        o_retire   = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_FETCH: o_imem_req = 1'b1;
                S_EXEC: begin
                    if (w_is_branch) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                    end
                end
                S_MEM: begin
                    o_dmem_ren = w_is_load;
                    o_dmem_wen = w_is_store;
                    if (w_is_store && i_dmem_valid) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                    end
                end
                S_WB: begin
                    o_rf_we  = |r_ir[11:7];
                    o_pc_we  = 1'b1;
                    o_retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at the register width.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retire_count <= '0;
        end else if (o_retire) begin
            r_retire_count <= r_retire_count + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_inst         = r_ir;
    assign o_format       = w_format;
    assign o_trap         = (r_state == S_TRAP);
    assign o_retire_count = r_retire_count;
    assign o_state        = r_state;

endmodule
